// File: rtl/mem_stage.sv
// Pipeline MEM stage: turns EX/MEM load/store requests into cache accesses and feeds MEM/WB.
// Optional load-linked/store-conditional support is compiled in with `define LLSC_EN.
module mem_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_dREN,
  input  logic        ex_dWEN,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_busB,
  input  logic        ex_rw,
  input  logic [4:0]  ex_wsel,
  input  logic        ex_halt,
  input  logic        ex_ll,
  input  logic        ex_sc,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        wb_rw,
  output logic [4:0]  wb_wsel,
  output logic [31:0] wb_wdat,
  output logic        wb_halt
);

  typedef enum logic [1:0] {StIdle, StBusy, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_data_q, req_data_d;
  logic [4:0]  req_wsel_q, req_wsel_d;
  logic        req_rw_q, req_rw_d;
  logic        req_store_q, req_store_d;
  logic        wb_rw_q, wb_rw_d;
  logic [4:0]  wb_wsel_q, wb_wsel_d;
  logic [31:0] wb_wdat_q, wb_wdat_d;
  logic        wb_halt_q, wb_halt_d;
  logic        mem_req;
  logic        busy;

`ifdef LLSC_EN
  logic        req_ll_q, req_ll_d;
  logic        req_sc_q, req_sc_d;
  logic        link_valid_q, link_valid_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic        sc_ok;
  logic        sc_fail;

  assign sc_ok   = ex_sc && link_valid_q && (link_addr_q == ex_result);
  assign sc_fail = ex_sc && !sc_ok;
  // A failing sc never reaches the cache; a passing one is issued as a store.
  assign mem_req = ((ex_dREN || ex_dWEN) && !ex_sc) || sc_ok;
`else
  logic unused_llsc;
  assign unused_llsc = ex_ll ^ ex_sc;
  assign mem_req     = ex_dREN || ex_dWEN;
`endif

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_wsel_d  = req_wsel_q;
    req_rw_d    = req_rw_q;
    req_store_d = req_store_q;
    wb_rw_d     = wb_rw_q;
    wb_wsel_d   = wb_wsel_q;
    wb_wdat_d   = wb_wdat_q;
    wb_halt_d   = wb_halt_q;
`ifdef LLSC_EN
    req_ll_d     = req_ll_q;
    req_sc_d     = req_sc_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
`endif

    case (state_q)
      StIdle: begin
        if (ex_halt) begin
          state_d   = StHalted;
          wb_halt_d = 1'b1;
          wb_rw_d   = 1'b0;
        end else if (mem_req) begin
          state_d     = StBusy;
          req_addr_d  = ex_result;
          req_data_d  = ex_busB;
          req_wsel_d  = ex_wsel;
          req_rw_d    = ex_rw;
          req_store_d = ex_dWEN;
          wb_rw_d     = 1'b0;
          wb_wsel_d   = ex_wsel;
`ifdef LLSC_EN
          req_store_d = ex_dWEN || ex_sc;
          req_ll_d    = ex_ll && ex_dREN && !ex_dWEN;
          req_sc_d    = ex_sc;
`endif
        end else begin
          wb_rw_d   = ex_rw;
          wb_wsel_d = ex_wsel;
          wb_wdat_d = ex_result;
`ifdef LLSC_EN
          if (sc_fail) begin
            wb_wdat_d    = 32'd0;
            link_valid_d = 1'b0;
          end
`endif
        end
      end

      StBusy: begin
        wb_rw_d = 1'b0;
        if (dhit) begin
          state_d   = StIdle;
          wb_wsel_d = req_wsel_q;
          if (!req_store_q) begin
            wb_wdat_d = dmemload;
            wb_rw_d   = req_rw_q;
          end
`ifdef LLSC_EN
          if (req_sc_q) begin
            wb_wdat_d    = 32'd1;
            wb_rw_d      = req_rw_q;
            link_valid_d = 1'b0;
          end else if (req_store_q && link_valid_q && (req_addr_q == link_addr_q)) begin
            link_valid_d = 1'b0;
          end else if (!req_store_q && req_ll_q) begin
            link_valid_d = 1'b1;
            link_addr_d  = req_addr_q;
          end
`endif
        end
      end

      StHalted: begin
        wb_rw_d = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_wsel_q  <= '0;
      req_rw_q    <= 1'b0;
      req_store_q <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_wsel_q   <= '0;
      wb_wdat_q   <= '0;
      wb_halt_q   <= 1'b0;
`ifdef LLSC_EN
      req_ll_q     <= 1'b0;
      req_sc_q     <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_wsel_q  <= req_wsel_d;
      req_rw_q    <= req_rw_d;
      req_store_q <= req_store_d;
      // Register 0 is hardwired, so a write to it is suppressed here.
      wb_rw_q     <= wb_rw_d && (wb_wsel_d != 5'd0);
      wb_wsel_q   <= wb_wsel_d;
      wb_wdat_q   <= wb_wdat_d;
      wb_halt_q   <= wb_halt_d;
`ifdef LLSC_EN
      req_ll_q     <= req_ll_d;
      req_sc_q     <= req_sc_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
`endif
    end
  end

  assign busy      = (state_q == StBusy);
  assign mem_stall = (state_q != StIdle);
  assign dmemREN   = busy && !req_store_q;
  assign dmemWEN   = busy && req_store_q;
  assign dmemaddr  = busy ? req_addr_q : 32'd0;
  assign dmemstore = busy ? req_data_q : 32'd0;

  assign wb_rw   = wb_rw_q;
  assign wb_wsel = wb_wsel_q;
  assign wb_wdat = wb_wdat_q;
  assign wb_halt = wb_halt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, load, store, reset, halt, LL/SC.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_dREN, ex_dWEN, ex_rw, ex_halt, ex_ll, ex_sc, dhit;
  logic [31:0] ex_result, ex_busB, dmemload;
  logic [4:0]  ex_wsel;
  logic        dmemREN, dmemWEN, mem_stall, wb_rw, wb_halt;
  logic [31:0] dmemaddr, dmemstore, wb_wdat;
  logic [4:0]  wb_wsel;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stage dut (
    .CLK       (CLK),
    .RST       (RST),
    .ex_dREN   (ex_dREN),
    .ex_dWEN   (ex_dWEN),
    .ex_result (ex_result),
    .ex_busB   (ex_busB),
    .ex_rw     (ex_rw),
    .ex_wsel   (ex_wsel),
    .ex_halt   (ex_halt),
    .ex_ll     (ex_ll),
    .ex_sc     (ex_sc),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .mem_stall (mem_stall),
    .wb_rw     (wb_rw),
    .wb_wsel   (wb_wsel),
    .wb_wdat   (wb_wdat),
    .wb_halt   (wb_halt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ex();
    ex_dREN = 0; ex_dWEN = 0; ex_rw = 0; ex_halt = 0; ex_ll = 0; ex_sc = 0;
    ex_result = '0; ex_busB = '0; ex_wsel = '0;
  endtask

  initial begin
    RST = 1; dhit = 0; dmemload = '0;
    clear_ex();
    step(); step();
    check("rst_stall", mem_stall, 0);
    check("rst_ren", dmemREN, 0);
    check("rst_wen", dmemWEN, 0);
    check("rst_wb_rw", wb_rw, 0);
    check("rst_wdat", wb_wdat, 0);
    check("rst_halt", wb_halt, 0);
    RST = 0;
    step();

    // ALU op passes straight through
    ex_rw = 1; ex_wsel = 5; ex_result = 32'h1234;
    check("alu_stall_pre", mem_stall, 0);
    step();
    check("alu_wdat", wb_wdat, 32'h1234);
    check("alu_rw", wb_rw, 1);
    check("alu_wsel", wb_wsel, 5);
    check("alu_stall", mem_stall, 0);

    // write to r0 is suppressed
    ex_rw = 1; ex_wsel = 0; ex_result = 32'h77;
    step();
    check("r0_rw", wb_rw, 0);
    check("r0_wdat", wb_wdat, 32'h77);

    // load with dhit on third BUSY cycle
    clear_ex();
    ex_dREN = 1; ex_rw = 1; ex_wsel = 7; ex_result = 32'h40;
    step();
    clear_ex();
    check("ld_bubble", wb_rw, 0);
    for (int i = 0; i < 3; i++) begin
      check("ld_ren", dmemREN, 1);
      check("ld_wen", dmemWEN, 0);
      check("ld_addr", dmemaddr, 32'h40);
      check("ld_stall", mem_stall, 1);
      if (i == 2) begin
        dhit = 1; dmemload = 32'hDEADBEEF;
      end
      step();
    end
    dhit = 0; dmemload = '0;
    check("ld_wdat", wb_wdat, 32'hDEADBEEF);
    check("ld_rw", wb_rw, 1);
    check("ld_wsel", wb_wsel, 7);
    check("ld_done_stall", mem_stall, 0);
    check("ld_done_ren", dmemREN, 0);
    check("ld_done_addr", dmemaddr, 0);

    // dREN and dWEN together behave as a store
    ex_dREN = 1; ex_dWEN = 1; ex_rw = 1; ex_wsel = 3; ex_result = 32'h80; ex_busB = 32'h55;
    step();
    clear_ex();
    check("st_wen", dmemWEN, 1);
    check("st_ren", dmemREN, 0);
    check("st_data", dmemstore, 32'h55);
    check("st_addr", dmemaddr, 32'h80);
    dhit = 1;
    #1;
    check("st_stall_on_hit", mem_stall, 1);
    step();
    dhit = 0;
    check("st_rw", wb_rw, 0);
    check("st_done_stall", mem_stall, 0);
    check("st_done_wen", dmemWEN, 0);
    check("st_done_data", dmemstore, 0);

    // reset in the middle of an access drops it
    ex_dREN = 1; ex_rw = 1; ex_wsel = 6; ex_result = 32'h200;
    step();
    clear_ex();
    check("rb_ren", dmemREN, 1);
    RST = 1;
    #1;
    check("rb_ren_async", dmemREN, 0);
    check("rb_stall_async", mem_stall, 0);
    step();
    RST = 0;
    step();
    check("rb_ren", dmemREN, 0);
    check("rb_wen", dmemWEN, 0);
    check("rb_stall", mem_stall, 0);
    ex_rw = 1; ex_wsel = 9; ex_result = 32'hABC;
    step();
    clear_ex();
    check("rb_idle_wdat", wb_wdat, 32'hABC);
    check("rb_idle_rw", wb_rw, 1);

`ifdef LLSC_EN
    ex_dREN = 1; ex_ll = 1; ex_rw = 1; ex_wsel = 2; ex_result = 32'h100;
    step();
    clear_ex();
    dhit = 1; dmemload = 32'h5;
    step();
    dhit = 0;
    check("ll_wdat", wb_wdat, 32'h5);
    ex_dWEN = 1; ex_sc = 1; ex_rw = 1; ex_wsel = 2; ex_result = 32'h100; ex_busB = 32'h9;
    step();
    clear_ex();
    check("sc1_wen", dmemWEN, 1);
    check("sc1_data", dmemstore, 32'h9);
    dhit = 1;
    step();
    dhit = 0;
    check("sc1_wdat", wb_wdat, 1);
    check("sc1_rw", wb_rw, 1);
    ex_dWEN = 1; ex_sc = 1; ex_rw = 1; ex_wsel = 2; ex_result = 32'h100; ex_busB = 32'h9;
    step();
    clear_ex();
    check("sc2_wen", dmemWEN, 0);
    check("sc2_stall", mem_stall, 0);
    check("sc2_wdat", wb_wdat, 0);
    check("sc2_rw", wb_rw, 1);
`endif

    // halt wins over a simultaneous store and sticks
    ex_halt = 1; ex_dWEN = 1; ex_rw = 1; ex_wsel = 4; ex_result = 32'h300; ex_busB = 32'h1;
    check("hlt_pre_wen", dmemWEN, 0);
    step();
    ex_halt = 0;
    for (int i = 0; i < 4; i++) begin
      check("hlt_halt", wb_halt, 1);
      check("hlt_stall", mem_stall, 1);
      check("hlt_wen", dmemWEN, 0);
      check("hlt_rw", wb_rw, 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The module SHALL have these ports (name  direction  width  meaning):
- CLK  in  1  sole clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ex_dREN  in  1  load request from EX/MEM register
- ex_dWEN  in  1  store request from EX/MEM register
- ex_result  in  32  ALU result / memory address
- ex_busB  in  32  store data
- ex_rw  in  1  register-write enable
- ex_wsel  in  5  destination register
- ex_halt  in  1  halt instruction reached MEM
- ex_ll  in  1  load-linked marker
- ex_sc  in  1  store-conditional marker
- dhit  in  1  data cache access complete
- dmemload  in  32  load data from cache
- dmemREN  out  1  cache read request
- dmemWEN  out  1  cache write request
- dmemaddr  out  32  cache address
- dmemstore  out  32  cache store data
- mem_stall  out  1  freeze upstream registers
- wb_rw  out  1  MEM/WB register-write enable
- wb_wsel  out  5  MEM/WB destination
- wb_wdat  out  32  MEM/WB write data
- wb_halt  out  1  sticky halt to writeback
REQ-002 Clock and reset SHALL be CLK and RST; one clock; RST asynchronous, active-high.

Function
REQ-003 FSM states SHALL be IDLE, BUSY, HALTED.
REQ-004 IDLE: mem_stall=0; inputs sampled each rising edge.
REQ-005 IDLE, no request, no halt: WB registers load ex_rw, ex_wsel, ex_result next edge (1-cycle latency).
REQ-006 IDLE with ex_dREN or ex_dWEN: latch address, store data, wsel, rw, type into request registers; wb_rw<=0 (bubble); go BUSY.
REQ-007 ex_dREN and ex_dWEN both high SHALL be treated as a store only.
REQ-008 BUSY: dmemREN/dmemWEN/dmemaddr/dmemstore driven from request registers only; mem_stall=1 for every BUSY cycle, including the dhit cycle.
REQ-009 BUSY with dhit: load -> wb_wdat<=dmemload, wb_rw<=latched rw; store -> wb_rw<=0; go IDLE.
REQ-010 BUSY without dhit: hold all state; wb_rw held 0; no timeout.
REQ-011 Outside BUSY, dmemREN=dmemWEN=0; dmemaddr and dmemstore SHALL be 0.
REQ-012 wb_rw SHALL be forced 0 whenever its wsel is 0.
REQ-013 IDLE with ex_halt: go HALTED; wb_halt<=1; halt has priority over a simultaneous memory request.
REQ-014 HALTED: mem_stall=1, wb_rw=0, no cache requests; exit only by RST.

Reset
REQ-015 RST high SHALL force IDLE, zero all outputs and request registers, and clear the link register, including mid-BUSY; the pending access is dropped.

Configuration
REQ-016 Macro LLSC_EN SHALL compile in load-linked/store-conditional support.
REQ-017 With LLSC_EN: an ll load completing on dhit sets link valid=1, link addr=dmemaddr.
REQ-018 With LLSC_EN: sc with link valid and address match performs the store via BUSY, then wb_wdat<=1 with latched wb_rw.
REQ-019 With LLSC_EN: sc on link mismatch or invalid link takes the IDLE path with no cache access; wb_wdat<=0 one cycle later.
REQ-020 With LLSC_EN: any completed sc or store to the linked address clears link valid.
REQ-021 Without LLSC_EN: ex_ll and ex_sc SHALL be ignored; no link register exists; behaviour is set by ex_dREN and ex_dWEN only.

Verification
REQ-022 ALU op (rw=1, wsel=5, result=0x1234): wb_wdat=0x1234 and wb_rw=1 one edge later; mem_stall never asserts.
REQ-023 Load addr=0x40 with dhit after 3 BUSY cycles, dmemload=0xDEADBEEF: dmemREN=1 and mem_stall=1 for 3 cycles; then wb_wdat=0xDEADBEEF and wb_rw=1.
REQ-024 ex_dREN=ex_dWEN=1, addr=0x80, busB=0x55: dmemWEN=1, dmemREN=0, dmemstore=0x55; wb_rw=0 after dhit.
REQ-025 RST pulsed in BUSY with dhit=0: next cycle dmemREN=dmemWEN=0, mem_stall=0, and the FSM is IDLE.
REQ-026 ex_halt with ex_dWEN=1: wb_halt=1 and mem_stall=1 permanently; dmemWEN is never asserted.
REQ-027 LLSC_EN: ll 0x100, sc 0x100 -> store issued, wb_wdat=1; second sc 0x100 -> no dmemWEN, wb_wdat=0.
